// File: rtl/dehaze_axis_framer_if.sv
// dehaze_axis_framer_if
// AXI4-Stream style bundle used on both sides of the framer.
//   tdata  : pixel word {8'h00, R, G, B}
//   tvalid : source has a word
//   tuser  : first pixel of a frame (used only by the master side)
//   tlast  : packet end
//   tready : sink can accept
// Modports:
//   master : drives tdata/tvalid/tuser/tlast, samples tready
//   slave  : samples tdata/tvalid/tlast, drives tready
interface dehaze_axis_framer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tuser;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  // Upstream TUSER is not part of the input contract, so it is left out here.
  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/dehaze_axis_framer.sv
// dehaze_axis_framer
// Output framing stage behind the haze-removal core. It buffers pixels in a
// small register FIFO, absorbs DMA backpressure and rebuilds the frame
// markers (TUSER / TLAST) from its own pixel counters. It also pulses a
// frame-done interrupt and flags misplaced upstream TLAST.
//
// Optional feature macro: FRAMER_LINE_TLAST_EN
//   defined     : TLAST on the last pixel of every line
//   not defined : TLAST only on the last pixel of the frame
//
// Ports:
//   ACLK      in   clock, all logic on the rising edge
//   ARESETn   in   synchronous active-low reset
//   enable    in   1 = accept input, 0 = stop accepting (FIFO keeps draining)
//   s_axis    slave  stream from the haze-removal core (TLAST checked only)
//   m_axis    master stream to the DMA with regenerated TUSER / TLAST
//   o_intr    out  one-cycle pulse after the last pixel of a frame leaves
//   o_err     out  sticky upstream TLAST misalignment flag
module dehaze_axis_framer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        enable,
  dehaze_axis_framer_if.slave         s_axis,
  dehaze_axis_framer_if.master        m_axis,
  output logic                        o_intr,
  output logic                        o_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int NW = $clog2(IMG_WIDTH * IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(IMG_WIDTH * IMG_HEIGHT - 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic [NW-1:0] in_cnt_reg, in_cnt_next;
  logic          intr_reg, intr_next;
  logic          err_reg, err_next;

  logic          full;
  logic          empty;
  logic          s_ready;
  logic          push;
  logic          pop;
  logic          col_at_last;
  logic          row_at_last;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic [DATA_W-1:0] entry [FIFO_DEPTH];

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Ready is forced low while reset is asserted so nothing is accepted then.
  assign s_ready = ARESETn && enable && !full;
  assign push    = s_axis.tvalid && s_ready;
  assign pop     = !empty && m_axis.tready;

  assign col_at_last = (col_reg == COL_LAST);
  assign row_at_last = (row_reg == ROW_LAST);

  // Storage: one register per entry, written only when the write pointer
  // selects it. A full FIFO never accepts, so the head entry stays stable
  // while the output is stalled.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;

      always_ff @(posedge ACLK) begin
        if (push && (wr_idx == AW'(gi))) begin
          entry_reg <= s_axis.tdata;
        end
      end

      assign entry[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    col_next    = col_reg;
    row_next    = row_reg;
    in_cnt_next = in_cnt_reg;
    intr_next   = 1'b0;
    err_next    = err_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      in_cnt_next = (in_cnt_reg == CNT_LAST) ? '0 : in_cnt_reg + 1'b1;
      // Only an early TLAST is an error; a missing one at frame end is
      // tolerated because the core drives it inconsistently.
      if (s_axis.tlast && (in_cnt_reg != CNT_LAST)) begin
        err_next = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (col_at_last) begin
        col_next = '0;
        row_next = row_at_last ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
      intr_next = col_at_last && row_at_last;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      col_reg    <= '0;
      row_reg    <= '0;
      in_cnt_reg <= '0;
      intr_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      col_reg    <= col_next;
      row_reg    <= row_next;
      in_cnt_reg <= in_cnt_next;
      intr_reg   <= intr_next;
      err_reg    <= err_next;
    end
  end

  assign s_axis.tready = s_ready;

  // Output sidebands are gated by valid so an empty FIFO presents all zeros.
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 : entry[rd_idx];
  assign m_axis.tuser  = !empty && (col_reg == '0) && (row_reg == '0);
`ifdef FRAMER_LINE_TLAST_EN
  assign m_axis.tlast  = !empty && col_at_last;
`else
  assign m_axis.tlast  = !empty && col_at_last && row_at_last;
`endif

  assign o_intr = intr_reg;
  assign o_err  = err_reg;

endmodule

// File: tb/tb_dehaze_axis_framer.sv
module tb_dehaze_axis_framer;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NPIX  = W * H;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic enable = 1'b0;
  logic o_intr;
  logic o_err;

  dehaze_axis_framer_if #(.DATA_W(DW)) s_if ();
  dehaze_axis_framer_if #(.DATA_W(DW)) m_if ();

  dehaze_axis_framer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK   (clk),
    .ARESETn(rstn),
    .enable (enable),
    .s_axis (s_if),
    .m_axis (m_if),
    .o_intr (o_intr),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } item_t;

  item_t sb[$];
  int    chk_cnt   = 0;
  int    pass_cnt  = 0;
  bit    mon_on    = 1'b0;
  int    in_idx    = 0;
  bit    intr_exp  = 1'b0;
  bit    err_exp   = 1'b0;
  int    intr_seen = 0;

  // Scoreboard monitor: expected items are queued on every accepted input
  // and compared whenever the DUT presents a word; o_intr / o_err are
  // compared every cycle against a reference model.
  always @(negedge clk) begin
    item_t h;
    logic  exp_user;
    logic  exp_last;
    if (mon_on) begin
      chk_cnt++;
      if (o_intr !== intr_exp)
        $display("FAIL intr: got %b want %b at %0t", o_intr, intr_exp, $time);
      else pass_cnt++;
      chk_cnt++;
      if (o_err !== err_exp)
        $display("FAIL err_flag: got %b want %b at %0t", o_err, err_exp, $time);
      else pass_cnt++;
      if (o_intr === 1'b1) intr_seen++;
      intr_exp = 1'b0;

      if (!rstn) begin
        sb.delete();
        in_idx  = 0;
        err_exp = 1'b0;
      end else begin
        if (m_if.tvalid === 1'b1) begin
          if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_out: got data %0d want no output at %0t", m_if.tdata, $time);
          end else begin
            h = sb[0];
            exp_user = (h.idx == 0);
`ifdef FRAMER_LINE_TLAST_EN
            exp_last = ((h.idx % W) == W - 1);
`else
            exp_last = (h.idx == NPIX - 1);
`endif
            chk_cnt++;
            if (m_if.tdata !== h.data)
              $display("FAIL out_data: got %0d want %0d (idx %0d)", m_if.tdata, h.data, h.idx);
            else pass_cnt++;
            chk_cnt++;
            if (m_if.tuser !== exp_user)
              $display("FAIL out_tuser: got %b want %b (idx %0d)", m_if.tuser, exp_user, h.idx);
            else pass_cnt++;
            chk_cnt++;
            if (m_if.tlast !== exp_last)
              $display("FAIL out_tlast: got %b want %b (idx %0d)", m_if.tlast, exp_last, h.idx);
            else pass_cnt++;
            if (m_if.tready === 1'b1) begin
              if (h.idx == NPIX - 1) intr_exp = 1'b1;
              void'(sb.pop_front());
              $display("pop  data=%0d idx=%0d tuser=%b tlast=%b t=%0t",
                       m_if.tdata, h.idx, m_if.tuser, m_if.tlast, $time);
            end
          end
        end
        if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
          if (s_if.tlast === 1'b1 && in_idx != NPIX - 1) err_exp = 1'b1;
          h.data = s_if.tdata;
          h.idx  = in_idx;
          sb.push_back(h);
          in_idx = (in_idx + 1) % NPIX;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_pixel(input logic [DW-1:0] d, input logic last);
    int waited;
    waited = 0;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready === 1'b1) break;
      waited++;
      if (waited > 200) begin
        chk_cnt++;
        $display("FAIL send_timeout: got tready=0 for %0d cycles want 1", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && m_if.tvalid !== 1'b0; k++) @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (m_if.tvalid !== 1'b0)
      $display("FAIL %s_drain: got tvalid=%b want 0", name, m_if.tvalid);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    enable      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (s_if.tready !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", s_if.tready);
    else pass_cnt++;
    chk_cnt++;
    if (m_if.tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_if.tvalid);
    else pass_cnt++;
    chk_cnt++;
    if (m_if.tdata !== '0) $display("FAIL reset_m_tdata: got %0h want 0", m_if.tdata);
    else pass_cnt++;
    chk_cnt++;
    if (m_if.tuser !== 1'b0 || m_if.tlast !== 1'b0)
      $display("FAIL reset_sideband: got tuser=%b tlast=%b want 0 0", m_if.tuser, m_if.tlast);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (s_if.tready !== 1'b1) $display("FAIL post_reset_tready: got %b want 1", s_if.tready);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int intr_before;
    intr_before = intr_seen;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      s_if.tdata = DW'(i);
      s_if.tlast = (i == NPIX - 1);
      @(negedge clk);
      chk_cnt++;
      if (s_if.tready !== 1'b1) $display("FAIL stream_ready: got %b want 1 (pixel %0d)", s_if.tready, i);
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== DW'(i - 1))
          $display("FAIL stream_latency: got valid=%b data=%0d want 1 %0d", m_if.tvalid, m_if.tdata, i - 1);
        else pass_cnt++;
      end
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== DW'(NPIX - 1))
      $display("FAIL stream_last: got valid=%b data=%0d want 1 %0d", m_if.tvalid, m_if.tdata, NPIX - 1);
    else pass_cnt++;
    @(posedge clk);
    #1;
    wait_drain("stream");
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (intr_seen - intr_before !== 1)
      $display("FAIL stream_intr_count: got %0d want 1", intr_seen - intr_before);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      s_if.tdata = DW'(100 + acc);
      @(negedge clk);
      if (s_if.tready === 1'b1) acc++;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (acc !== DEPTH) $display("FAIL bp_accept_count: got %0d want %0d", acc, DEPTH);
    else pass_cnt++;
    chk_cnt++;
    if (s_if.tready !== 1'b0) $display("FAIL bp_tready: got %b want 0", s_if.tready);
    else pass_cnt++;
    chk_cnt++;
    if (m_if.tdata !== DW'(100)) $display("FAIL bp_hold_data: got %0d want 100", m_if.tdata);
    else pass_cnt++;
    @(posedge clk);
    #1;
    m_if.tready = 1'b1;
    if (acc > NPIX) acc = NPIX;
    for (int i = acc; i < NPIX; i++) send_pixel(DW'(100 + i), 1'b0);
    wait_drain("bp");
  endtask

  task automatic test_tlast_error();
    chk_cnt++;
    if (o_err !== 1'b0) $display("FAIL err_before: got %b want 0", o_err);
    else pass_cnt++;
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(DW'(200 + i), (i == 5) || (i == NPIX - 1));
      if (i == 5) begin
        @(negedge clk);
        chk_cnt++;
        if (o_err !== 1'b1) $display("FAIL err_set: got %b want 1", o_err);
        else pass_cnt++;
        @(posedge clk);
        #1;
      end
    end
    wait_drain("err");
    chk_cnt++;
    if (o_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", o_err);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 12; i++) send_pixel(DW'(300 + i), 1'b0);
    enable      = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = DW'(312);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (s_if.tready !== 1'b0) $display("FAIL en_tready: got %b want 0 (cycle %0d)", s_if.tready, c);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (m_if.tvalid !== 1'b0) $display("FAIL en_drained: got tvalid=%b want 0", m_if.tvalid);
    else pass_cnt++;
    @(posedge clk);
    #1;
    enable = 1'b1;
    for (int i = 12; i < NPIX; i++) send_pixel(DW'(300 + i), 1'b0);
    wait_drain("en");
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 18; i++) send_pixel(DW'(400 + i), 1'b0);
    m_if.tready = 1'b0;
    for (int i = 18; i < 20; i++) send_pixel(DW'(400 + i), 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (s_if.tready !== 1'b0) $display("FAIL mid_rst_tready: got %b want 0", s_if.tready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0)
      $display("FAIL mid_rst_flush: got valid=%b data=%0d want 0 0", m_if.tvalid, m_if.tdata);
    else pass_cnt++;
    chk_cnt++;
    if (o_err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", o_err);
    else pass_cnt++;
    @(posedge clk);
    #1;
    m_if.tready = 1'b1;
    send_pixel(DW'(500), 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (m_if.tuser !== 1'b1 || m_if.tdata !== DW'(500))
      $display("FAIL mid_rst_tuser: got tuser=%b data=%0d want 1 500", m_if.tuser, m_if.tdata);
    else pass_cnt++;
    @(posedge clk);
    #1;
    for (int i = 1; i < NPIX; i++) send_pixel(DW'(500 + i), 1'b0);
    wait_drain("mid_rst");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_tlast_error();
    test_enable();
    test_reset_midframe();
    chk_cnt++;
    if (sb.size() !== 0) $display("FAIL sb_empty: got %0d pending want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dehaze_axis_framer.md
# dehaze_axis_framer

Output framing stage placed directly downstream of `DCP_HazeRemoval`'s master AXI4-Stream port. It buffers recovered RGB pixels in a small FIFO and absorbs DMA backpressure. It regenerates frame markers from pixel counters: TUSER on start-of-frame, TLAST at end-of-line or end-of-frame. It also raises a one-cycle frame-done interrupt and flags upstream TLAST misalignment.

## Interface
- `IMG_WIDTH`, 512, pixels per line (≥2)
- `IMG_HEIGHT`, 512, lines per frame (≥1)
- `DATA_W`, 32, stream data width; {8'h00, R, G, B}
- `FIFO_DEPTH`, 4, entries, power of two ≥2
- `ACLK`  in  1  single clock, all logic on rising edge
- `ARESETn`  in  1  reset, synchronous, active-low
- `enable`  in  1  1 = accept input; 0 = stop accepting, keep draining
- `S_AXIS_TDATA`  in  DATA_W  pixel from haze-removal core
- `S_AXIS_TVALID`  in  1  input valid
- `S_AXIS_TLAST`  in  1  upstream end-of-frame; checked only, never forwarded
- `S_AXIS_TREADY`  out  1  input ready
- `M_AXIS_TDATA`  out  DATA_W  buffered pixel
- `M_AXIS_TVALID`  out  1  output valid
- `M_AXIS_TUSER`  out  1  first pixel of frame
- `M_AXIS_TLAST`  out  1  line/frame end (see Configuration)
- `M_AXIS_TREADY`  in  1  downstream ready
- `o_intr`  out  1  one-cycle pulse: last frame pixel accepted on master side
- `o_err`  out  1  sticky: upstream TLAST misaligned; cleared only by reset

## Operation
- Input handshake: push when `S_AXIS_TVALID && S_AXIS_TREADY`. `S_AXIS_TREADY = enable && !full`. No bypass when full.
- FIFO is register-based with `FIFO_DEPTH` entries. Read and write pointers are log2(FIFO_DEPTH)+1 bits. Full means MSBs differ and LSBs are equal. Empty means the pointers are equal. Push and pop in the same cycle leave the occupancy unchanged.
- Output: `M_AXIS_TVALID = !empty`. Pop when `M_AXIS_TVALID && M_AXIS_TREADY`. TDATA, TUSER and TLAST are held stable while TVALID=1 and TREADY=0.
- Output counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance on each pop. `col` wraps to 0 and increments `row`. `row` wraps to 0 after the last line.
- `M_AXIS_TUSER = (col==0 && row==0)`.
- `o_intr` pulses the cycle after the pop where col==IMG_WIDTH-1 and row==IMG_HEIGHT-1.
- Input counter `in_cnt` (0..W·H-1) advances on each push and wraps at frame end.
- `o_err` sets if `S_AXIS_TLAST`=1 on a push with in_cnt≠W·H-1.
- `o_err` does not set when TLAST=0 at the frame end, because the core drives TLAST inconsistently. Counters stay authoritative in both cases.
- `enable`=0 only deasserts `S_AXIS_TREADY`. The FIFO drains and counters keep their values. Re-enabling resumes mid-frame.

## Timing
- Reset (ARESETn=0 sampled at an edge): pointers, col, row, in_cnt = 0, o_err = 0, o_intr = 0.
- Outputs the cycle after reset: `S_AXIS_TREADY`=0 while ARESETn=0, and `M_AXIS_TVALID`=0. `M_AXIS_TDATA`=0, TUSER=0 (gated by valid), TLAST=0.
- Latency: a pixel pushed at edge N is presented on M_AXIS from edge N+1, when the FIFO was empty.
- Throughput: 1 pixel/cycle sustained with TREADY=1.
- Full FIFO: with downstream stalled, input stalls after FIFO_DEPTH pushes. `S_AXIS_TREADY` returns the cycle after the first pop.
- Reset mid-frame: the FIFO is flushed without output and partial counts are discarded. The next pushed pixel carries TUSER=1.
- Simultaneous frame-end pop and push of the next frame's first pixel: `o_intr` pulses, and the new pixel presents TUSER=1.

## Configuration
- `FRAMER_LINE_TLAST_EN` defined: TLAST=1 on every col==IMG_WIDTH-1, matching the video line convention.
- Not defined: TLAST=1 only at col==IMG_WIDTH-1 && row==IMG_HEIGHT-1, giving one packet per frame for simple DMA.
- TUSER, `o_intr` and `o_err` behave identically in both builds.

## Test plan
- W=8, H=4, TREADY=1, 32 pixels 0..31 streamed back-to-back:
  - TDATA appears in order with 1-cycle latency.
  - TUSER is set on pixel 0 only.
  - `o_intr` pulses once, after pixel 31.
- Line TLAST, both builds:
  - With `FRAMER_LINE_TLAST_EN`: TLAST on pixels 7, 15, 23, 31.
  - Without it: TLAST on pixel 31 only.
- Backpressure, FIFO_DEPTH=4, M_AXIS_TREADY=0 for 10 cycles:
  - Exactly 4 pushes are accepted, then `S_AXIS_TREADY`=0.
  - TDATA is held at pixel 0.
  - After release, no pixel is lost or duplicated.
- Upstream TLAST=1 on input pixel 5 → `o_err`=1 from the next cycle and sticky. Output framing is unchanged, still ending at pixel 31.
- `enable`=0 after 12 pushes for 6 cycles → no pushes, the FIFO drains, counters hold. Resume → TUSER is not reasserted and TLAST (line build) falls on pixel 15.
- ARESETn=0 for 1 cycle after 20 pixels → M_AXIS_TVALID=0 and counters clear. The next input pixel is output with TUSER=1, and `o_err` is cleared.
